// File: rtl/cordic_pkg.sv
// Shared Q2.14 phase constants, types and helpers for the CORDIC phase source.
// Optional chirp support is selected with CORDIC_PHASE_CHIRP_EN (see cordic_phase_gen).
package cordic_pkg;

    typedef logic signed [31:0] phase_t;

    localparam phase_t PI_Q14      = 32'sh0000C90F;
    localparam phase_t TWO_PI_Q14  = 32'sh0001921F;
    localparam phase_t HALF_PI_Q14 = 32'sh00006488;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT,
        DONE
    } phase_state_t;

    // A single correction is enough because every caller keeps |x| <= 3*PI.
    function automatic phase_t wrap_phase(input phase_t x);
        if (x > PI_Q14)
            return x - TWO_PI_Q14;
        else if (x < -PI_Q14)
            return x + TWO_PI_Q14;
        else
            return x;
    endfunction

    function automatic phase_t clamp_step(input phase_t s);
        if (s > PI_Q14)
            return PI_Q14;
        else if (s < -PI_Q14)
            return -PI_Q14;
        else
            return s;
    endfunction

    function automatic logic step_out_of_range(input phase_t s);
        return (s > PI_Q14) || (s < -PI_Q14);
    endfunction

endpackage

// File: rtl/cordic_phase_gen_if.sv
// Control/configuration and sample bus between a burst requester and cordic_phase_gen.
// phase_step_delta exists only when CORDIC_PHASE_CHIRP_EN is defined.
interface cordic_phase_gen_if #(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 8
);
    logic                      start;
    logic                      stop;
    logic signed [PHASE_W-1:0] phase_init;
    logic signed [PHASE_W-1:0] phase_step;
`ifdef CORDIC_PHASE_CHIRP_EN
    logic signed [PHASE_W-1:0] phase_step_delta;
`endif
    logic        [CNT_W-1:0]   num_samples;
    logic        [DIV_W-1:0]   rate_div;
    logic                      valid_out;
    logic signed [PHASE_W-1:0] theta_out;
    logic                      busy;
    logic                      done;
    logic                      step_clamped;

`ifdef CORDIC_PHASE_CHIRP_EN
    modport master (
        output start, stop, phase_init, phase_step, phase_step_delta, num_samples, rate_div,
        input  valid_out, theta_out, busy, done, step_clamped
    );
    modport slave (
        input  start, stop, phase_init, phase_step, phase_step_delta, num_samples, rate_div,
        output valid_out, theta_out, busy, done, step_clamped
    );
`else
    modport master (
        output start, stop, phase_init, phase_step, num_samples, rate_div,
        input  valid_out, theta_out, busy, done, step_clamped
    );
    modport slave (
        input  start, stop, phase_init, phase_step, num_samples, rate_div,
        output valid_out, theta_out, busy, done, step_clamped
    );
`endif

endinterface

// File: rtl/cordic_phase_gen.sv
// Burst phase generator feeding the CORDIC pipeline: wrapped phase accumulation, paced by rate_div.
// Define CORDIC_PHASE_CHIRP_EN to add a per-sample step increment (linear chirp).
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    cordic_phase_gen_if.slave bus
);

    phase_state_t     state;
    phase_t           acc;
    phase_t           step;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] divcnt;
    logic [CNT_W-1:0] n;
    logic [CNT_W-1:0] cnt;

    phase_t init_wrapped;
    phase_t step_sat;
    logic   step_over;
    phase_t acc_next;

    assign init_wrapped = wrap_phase(bus.phase_init);
    assign step_sat     = clamp_step(bus.phase_step);
    assign step_over    = step_out_of_range(bus.phase_step);
    assign acc_next     = wrap_phase(acc + step);

`ifdef CORDIC_PHASE_CHIRP_EN
    phase_t step_delta;
    phase_t step_sum;
    phase_t step_chirp;
    logic   chirp_over;

    assign step_sum   = step + step_delta;
    assign step_chirp = clamp_step(step_sum);
    assign chirp_over = step_out_of_range(step_sum);
`endif

    // Outputs are loaded on the transition into the state that presents them, so they stay registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            acc              <= '0;
            step             <= '0;
            div              <= '0;
            divcnt           <= '0;
            n                <= '0;
            cnt              <= '0;
            bus.valid_out    <= 1'b0;
            bus.theta_out    <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.step_clamped <= 1'b0;
`ifdef CORDIC_PHASE_CHIRP_EN
            step_delta       <= '0;
`endif
        end else begin
            bus.valid_out <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        acc              <= init_wrapped;
                        step             <= step_sat;
                        div              <= bus.rate_div;
                        divcnt           <= '0;
                        n                <= bus.num_samples;
                        cnt              <= '0;
                        bus.step_clamped <= step_over;
                        bus.busy         <= 1'b1;
`ifdef CORDIC_PHASE_CHIRP_EN
                        step_delta       <= bus.phase_step_delta;
`endif
                        if (bus.num_samples != '0) begin
                            state         <= EMIT;
                            bus.valid_out <= 1'b1;
                            bus.theta_out <= init_wrapped;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
`ifdef CORDIC_PHASE_CHIRP_EN
                    step <= step_chirp;
                    if (chirp_over)
                        bus.step_clamped <= 1'b1;
`endif
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (cnt == n - CNT_W'(1)) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else if (div == '0) begin
                        state         <= EMIT;
                        bus.valid_out <= 1'b1;
                        bus.theta_out <= acc_next;
                    end else begin
                        state  <= WAIT;
                        divcnt <= div;
                    end
                end
                WAIT: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else if (divcnt == DIV_W'(1)) begin
                        state         <= EMIT;
                        bus.valid_out <= 1'b1;
                        bus.theta_out <= acc;
                    end else begin
                        divcnt <= divcnt - DIV_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Scoreboard bench for cordic_phase_gen: expected thetas queued at issue, popped by a negedge monitor.
// Built without CORDIC_PHASE_CHIRP_EN; the delta input is tied to zero if the macro is set.
module tb_cordic_phase_gen;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [31:0] exp_q[$];

    cordic_phase_gen_if intf ();

    cordic_phase_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Waits for the next negedge, then issues start so it is sampled at the following posedge (edge T).
    task automatic applyStimulus(input logic [31:0] init, input logic [31:0] step,
                                 input logic [15:0] n, input logic [7:0] div);
        @(negedge clk);
        intf.phase_init  = init;
        intf.phase_step  = step;
        intf.num_samples = n;
        intf.rate_div    = div;
        intf.start       = 1'b1;
        @(posedge clk);
        #1;
        intf.start = 1'b0;
    endtask

    // Bit k of each mask is the expected value in cycle T+k+1.
    task automatic runWindow(input string tag, input int cycles,
                             input logic [15:0] vmask, input logic [15:0] dmask, input logic [15:0] bmask);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            checkOutput($sformatf("%s_valid_c%0d", tag, k + 1), {31'd0, intf.valid_out}, {31'd0, vmask[k]});
            checkOutput($sformatf("%s_done_c%0d", tag, k + 1), {31'd0, intf.done}, {31'd0, dmask[k]});
            checkOutput($sformatf("%s_busy_c%0d", tag, k + 1), {31'd0, intf.busy}, {31'd0, bmask[k]});
        end
    endtask

    always @(negedge clk) begin
        if (intf.valid_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_sample actual=%h expected=none", intf.theta_out);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (intf.theta_out !== e) begin
                    bad++;
                    $display("[TB] FAIL theta actual=%h expected=%h", intf.theta_out, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        intf.start       = 1'b0;
        intf.stop        = 1'b0;
        intf.phase_init  = '0;
        intf.phase_step  = '0;
        intf.num_samples = '0;
        intf.rate_div    = '0;
`ifdef CORDIC_PHASE_CHIRP_EN
        intf.phase_step_delta = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", {31'd0, intf.valid_out}, 32'd0);
        checkOutput("rst_theta", intf.theta_out, 32'd0);
        checkOutput("rst_busy", {31'd0, intf.busy}, 32'd0);
        checkOutput("rst_done", {31'd0, intf.done}, 32'd0);
        checkOutput("rst_clamped", {31'd0, intf.step_clamped}, 32'd0);
        reset = 1'b1;

        // Basic ramp, back-to-back samples.
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00001000);
        exp_q.push_back(32'h00002000);
        exp_q.push_back(32'h00003000);
        applyStimulus(32'h0, 32'h1000, 16'd4, 8'd0);
        runWindow("t1", 6, 16'h000F, 16'h0010, 16'h001F);

        // Positive overflow wraps to the negative side.
        exp_q.push_back(32'h0000C000);
        exp_q.push_back(32'hFFFF3DE1);
        applyStimulus(32'h0000C000, 32'h1000, 16'd2, 8'd0);
        runWindow("t2", 4, 16'h0003, 16'h0004, 16'h0007);

        // Start at exactly -PI, then step below it and wrap to the positive side.
        exp_q.push_back(32'hFFFF36F1);
        exp_q.push_back(32'h0000B910);
        applyStimulus(32'hFFFF36F1, 32'hFFFFF000, 16'd2, 8'd0);
        runWindow("t3", 4, 16'h0003, 16'h0004, 16'h0007);

        // Rate divider: samples three cycles apart, done right after the last one.
        exp_q.push_back(32'h00000100);
        exp_q.push_back(32'h00000200);
        exp_q.push_back(32'h00000300);
        applyStimulus(32'h100, 32'h100, 16'd3, 8'd2);
        runWindow("t4a", 9, 16'h0049, 16'h0080, 16'h00FF);

        applyStimulus(32'h100, 32'h100, 16'd0, 8'd0);
        runWindow("t4b", 3, 16'h0000, 16'h0001, 16'h0001);

        // Oversized positive step saturates to PI.
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h0000C90F);
        exp_q.push_back(32'hFFFFFFFF);
        applyStimulus(32'h0, 32'h00020000, 16'd3, 8'd0);
        runWindow("t5a", 5, 16'h0007, 16'h0008, 16'h000F);
        checkOutput("t5a_clamped", {31'd0, intf.step_clamped}, 32'd1);

        // Step exactly PI is legal and lands on PI without wrapping.
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h0000C90F);
        applyStimulus(32'h0, 32'h0000C90F, 16'd2, 8'd0);
        runWindow("t5b", 4, 16'h0003, 16'h0004, 16'h0007);
        checkOutput("t5b_clamped", {31'd0, intf.step_clamped}, 32'd0);

        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'hFFFF36F1);
        applyStimulus(32'h0, 32'hFFFE0000, 16'd2, 8'd0);
        runWindow("t5c", 4, 16'h0003, 16'h0004, 16'h0007);
        checkOutput("t5c_clamped", {31'd0, intf.step_clamped}, 32'd1);

        // Start angle beyond PI is wrapped once at capture.
        exp_q.push_back(32'hFFFFEDE1);
        applyStimulus(32'h00018000, 32'h0, 16'd1, 8'd0);
        runWindow("t5d", 3, 16'h0001, 16'h0002, 16'h0003);
        checkOutput("t5d_clamped", {31'd0, intf.step_clamped}, 32'd0);

        intf.stop = 1'b1;
        applyStimulus(32'h0, 32'h10, 16'd4, 8'd0);
        intf.stop = 1'b0;
        runWindow("idle_stop", 3, 16'h0000, 16'h0000, 16'h0000);

        // Abort after the third sample.
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h00000010);
        exp_q.push_back(32'h00000020);
        applyStimulus(32'h0, 32'h10, 16'd10, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checkOutput($sformatf("t6_valid_c%0d", k), {31'd0, intf.valid_out}, (k <= 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t6_busy_c%0d", k), {31'd0, intf.busy}, (k <= 3) ? 32'd1 : 32'd0);
            checkOutput($sformatf("t6_done_c%0d", k), {31'd0, intf.done}, 32'd0);
            if (k == 3) intf.stop = 1'b1;
            if (k == 4) intf.stop = 1'b0;
        end

        // Reset mid-burst with a clamped step so the sticky flag is also cleared.
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h0000C90F);
        applyStimulus(32'h0, 32'h00020000, 16'd10, 8'd0);
        @(negedge clk);
        checkOutput("t7_clamped_before", {31'd0, intf.step_clamped}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t7_valid", {31'd0, intf.valid_out}, 32'd0);
        checkOutput("t7_theta", intf.theta_out, 32'd0);
        checkOutput("t7_busy", {31'd0, intf.busy}, 32'd0);
        checkOutput("t7_done", {31'd0, intf.done}, 32'd0);
        checkOutput("t7_clamped", {31'd0, intf.step_clamped}, 32'd0);
        reset = 1'b1;
        runWindow("t7_after", 3, 16'h0000, 16'h0000, 16'h0000);

        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
